// File: rtl/pak_checker_pkg.sv
// pak_checker_pkg: shared packet sizes, link FSM states and saturating counter helper
package pak_checker_pkg;
  localparam int NS_ADDRESS_SIZE = 4;
  localparam int NS_DATA_SIZE = 4;
  localparam int NS_REDUN_SIZE = 4;
  localparam int NS_PACKET_SIZE = NS_ADDRESS_SIZE + NS_DATA_SIZE + NS_REDUN_SIZE;
  typedef enum logic [1:0] {IDLE, CHECK, ACK_HI, ACK_LO} state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return c == 8'hFF ? c : c + 8'd1;
  endfunction
endpackage

// File: rtl/pak_req_sync.sv
// pak_req_sync: 2-flop synchronizer with synchronous reset
module pak_req_sync (
  input  logic i_clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge i_clk)
    if (reset) {q, s1} <= 2'b00;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/pak_checker.sv
// pak_checker: 4-phase packet sink checking address range and redundancy, with saturating counters
// Optional NS_PAK_CHK_SEQ_EN adds a data sequence checker and its error counter.
module pak_checker
  import pak_checker_pkg::*;
#(
  parameter int PSZ = NS_PACKET_SIZE,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 14
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [PSZ-1:0] rcv0_data,
  input  logic [3:0]     dbg_case,
  output logic [3:0]     dbg_leds,
  output logic [3:0]     dbg_disp0,
  output logic [3:0]     dbg_disp1
);
  localparam int SW = (ASZ > DSZ ? ASZ : DSZ) + 1;
  state_t state;
  logic req_s, addr_ok, redun_ok, seq_bad;
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] data;
  logic [RSZ-1:0] redun;
  logic [SW-1:0] sum;
  logic [7:0] cnt_ok, cnt_addr_err, cnt_redun_err, cnt_seq_err, last_pak;
  pak_req_sync u_sync (.i_clk(i_clk), .reset(reset), .d(rcv0_req), .q(req_s));
  assign addr = rcv0_data[PSZ-1 -: ASZ];
  assign data = rcv0_data[DSZ+RSZ-1 -: DSZ];
  assign redun = rcv0_data[RSZ-1:0];
  assign sum = SW'(addr) + SW'(data);
  assign addr_ok = addr >= ASZ'(MIN_ADDR) && addr <= ASZ'(MAX_ADDR);
  assign redun_ok = redun == RSZ'(sum);
`ifdef NS_PAK_CHK_SEQ_EN
  logic [DSZ-1:0] prev_data;
  logic seq_valid;
  assign seq_bad = seq_valid && data != prev_data + DSZ'(1);
  always_ff @(posedge i_clk)
    if (reset) begin
      cnt_seq_err <= '0;
      prev_data <= '0;
      seq_valid <= 1'b0;
    end else if (state == CHECK) begin
      if (seq_bad) cnt_seq_err <= sat_inc(cnt_seq_err);
      prev_data <= data;
      seq_valid <= 1'b1;
    end
`else
  assign seq_bad = 1'b0;
  assign cnt_seq_err = '0;
`endif
  always_ff @(posedge i_clk)
    if (reset) begin
      state <= IDLE;
      rcv0_ack <= 1'b0;
      cnt_ok <= '0;
      cnt_addr_err <= '0;
      cnt_redun_err <= '0;
      last_pak <= '0;
    end else begin
      case (state)
        IDLE: state <= req_s ? CHECK : IDLE;
        CHECK: begin
          state <= ACK_HI;
          rcv0_ack <= 1'b1;
          last_pak <= 8'(rcv0_data);
          if (addr_ok && redun_ok && !seq_bad) cnt_ok <= sat_inc(cnt_ok);
          if (!addr_ok) cnt_addr_err <= sat_inc(cnt_addr_err);
          if (!redun_ok) cnt_redun_err <= sat_inc(cnt_redun_err);
        end
        ACK_HI: if (!req_s) begin
          state <= ACK_LO;
          rcv0_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge i_clk)
    if (reset) {dbg_disp1, dbg_disp0} <= '0;
    else {dbg_disp1, dbg_disp0} <= dbg_case == 4'd0 ? cnt_ok :
                                   dbg_case == 4'd1 ? cnt_addr_err :
                                   dbg_case == 4'd2 ? cnt_redun_err :
                                   dbg_case == 4'd3 ? cnt_seq_err :
                                   dbg_case == 4'd4 ? last_pak : 8'h00;
  assign dbg_leds = {|cnt_seq_err, |cnt_redun_err, |cnt_addr_err, state != IDLE};
endmodule

// File: tb/tb_pak_checker.sv
// tb_pak_checker: directed handshake, range, redundancy, saturation and reset-abort checks
module tb_pak_checker;
  logic clk = 0, reset = 1, rcv0_req = 0, rcv0_ack;
  logic [11:0] rcv0_data = '0;
  logic [3:0] dbg_case = '0, dbg_leds, dbg_disp0, dbg_disp1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pak_checker dut (.i_clk(clk), .reset(reset), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
                   .rcv0_data(rcv0_data), .dbg_case(dbg_case), .dbg_leds(dbg_leds),
                   .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    forever begin
      @(posedge clk) #1;
      if (rcv0_ack == lvl || n > 20) break;
      n++;
    end
    chk(lvl ? "ack_rise" : "ack_fall", rcv0_ack, lvl);
  endtask
  task automatic send(input logic [3:0] a, d, r, output int lat);
    int n;
    @(negedge clk) rcv0_data = {a, d, r};
    rcv0_req = 1;
    wait_ack(1, lat);
    @(negedge clk) rcv0_req = 0;
    wait_ack(0, n);
    repeat (2) @(posedge clk);
  endtask
  task automatic rd(input logic [3:0] c, output int v);
    @(negedge clk) dbg_case = c;
    @(posedge clk) #1;
    v = {dbg_disp1, dbg_disp0};
  endtask
  initial begin
    int lat, v;
    do_reset();
    #1;
    chk("rst_ack", rcv0_ack, 0);
    chk("rst_leds", dbg_leds, 0);
    chk("rst_disp", {dbg_disp1, dbg_disp0}, 0);
`ifdef NS_PAK_CHK_SEQ_EN
    send(1, 0, 1, lat);
    send(1, 1, 2, lat);
    send(1, 2, 3, lat);
    send(1, 4, 5, lat);
    send(1, 5, 6, lat);
    rd(3, v); chk("seq_err", v, 1);
    rd(0, v); chk("seq_ok", v, 4);
    chk("seq_led", dbg_leds, 4'b1000);
`else
    send(5, 3, 8, lat);
    chk("ack_latency", lat, 3);
    rd(0, v); chk("first_ok", v, 8'h01);
    rd(4, v); chk("last_pak", v, 8'h38);
    @(negedge clk) dbg_case = 0;
    #1 chk("disp_lag", {dbg_disp1, dbg_disp0}, 8'h38);
    send(1, 2, 3, lat);
    send(14, 1, 15, lat);
    send(0, 2, 2, lat);
    send(15, 0, 15, lat);
    rd(0, v); chk("bound_ok", v, 3);
    rd(1, v); chk("bound_addr_err", v, 2);
    chk("bound_leds", dbg_leds, 4'b0010);
    send(5, 3, 7, lat);
    rd(2, v); chk("redun_err", v, 1);
    rd(0, v); chk("redun_ok_hold", v, 3);
    send(0, 4, 0, lat);
    rd(1, v); chk("both_addr", v, 3);
    rd(2, v); chk("both_redun", v, 2);
    rd(0, v); chk("both_ok_hold", v, 3);
    chk("both_leds", dbg_leds, 4'b0110);
    rd(3, v); chk("no_seq_disp", v, 0);
    rd(5, v); chk("case5", v, 0);
    rd(15, v); chk("case15", v, 0);
    do_reset();
    for (int i = 0; i < 300; i++) send(1, 1, 2, lat);
    rd(0, v); chk("sat_ok", v, 8'hFF);
    rd(1, v); chk("sat_addr", v, 0);
    rd(2, v); chk("sat_redun", v, 0);
    do_reset();
    @(negedge clk) rcv0_data = {4'd2, 4'd2, 4'd4};
    rcv0_req = 1;
    wait_ack(1, lat);
    chk("busy_led", dbg_leds[0], 1);
    @(negedge clk) reset = 1;
    @(posedge clk) #1;
    chk("abort_ack", rcv0_ack, 0);
    @(negedge clk) reset = 0;
    wait_ack(1, lat);
    @(negedge clk) rcv0_req = 0;
    wait_ack(0, lat);
    repeat (2) @(posedge clk);
    rd(0, v); chk("reaccept_ok", v, 1);
    rd(4, v); chk("reaccept_pak", v, 8'h24);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
